// File: rtl/dest_reg_scoreboard.sv
// -----------------------------------------------------------------------------
// dest_reg_scoreboard
//
// Tracks in-flight register writes for the 32 general-purpose registers.
// Each register r (1..31) has a CNT_W-bit pending-write counter. Decode may
// issue an instruction only when:
//   - none of its read sources has a pending write, and
//   - its destination counter has room for one more write.
// Write-back retires one destination per cycle.
//
// Parameters:
//   CNT_W      width of each pending-write counter (max 2^CNT_W-1 writes)
//   WB_BYPASS  1: a same-cycle retire releases a source hazard whose count is 1
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   issue_valid        decode presents an instruction
//   issue_ready        instruction may be accepted (combinational)
//   issue_we           instruction writes issue_rd
//   issue_rd           destination register number
//   issue_rs/issue_rt  source register numbers
//   issue_use_rs/_rt   the matching source is actually read
//   wb_valid, wb_rd    write-back retires one write to wb_rd
//   busy[31:0]         bit i set while register i has pending writes
//   stall              issue_valid && !issue_ready
//   err                sticky retire-underflow flag
// -----------------------------------------------------------------------------
module dest_reg_scoreboard #(
    parameter int CNT_W     = 2,
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        issue_valid,
    output logic        issue_ready,
    input  logic        issue_we,
    input  logic [4:0]  issue_rd,
    input  logic [4:0]  issue_rs,
    input  logic [4:0]  issue_rt,
    input  logic        issue_use_rs,
    input  logic        issue_use_rt,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    output logic [31:0] busy,
    output logic        stall,
    output logic        err
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Entry 0 exists only so every 5-bit index is in range; it stays zero.
    logic [CNT_W-1:0] cnt_q [32];

    logic [CNT_W-1:0] cnt_rs;
    logic [CNT_W-1:0] cnt_rt;
    logic [CNT_W-1:0] cnt_rd;
    logic [CNT_W-1:0] cnt_wb;
    logic             hazard_rs;
    logic             hazard_rt;
    logic             full_rd;
    logic             issue_fire;
    logic             underflow;
    logic [31:0]      inc;
    logic [31:0]      dec;

    assign cnt_rs = cnt_q[issue_rs];
    assign cnt_rt = cnt_q[issue_rt];
    assign cnt_rd = cnt_q[issue_rd];
    assign cnt_wb = cnt_q[wb_rd];

    always_comb begin
        hazard_rs = issue_use_rs && (issue_rs != 5'd0) && (cnt_rs != '0);
        // Zero-cycle release: the last pending write retires this very cycle.
        if (WB_BYPASS && wb_valid && (wb_rd == issue_rs) && (cnt_rs == CNT_ONE))
            hazard_rs = 1'b0;

        hazard_rt = issue_use_rt && (issue_rt != 5'd0) && (cnt_rt != '0);
        if (WB_BYPASS && wb_valid && (wb_rd == issue_rt) && (cnt_rt == CNT_ONE))
            hazard_rt = 1'b0;

        // A same-cycle retire of the same register frees a slot, so net count holds.
        full_rd = issue_we && (issue_rd != 5'd0) && (cnt_rd == CNT_MAX)
                  && !(wb_valid && (wb_rd == issue_rd));
    end

    assign issue_ready = !hazard_rs && !hazard_rt && !full_rd;
    assign stall       = issue_valid && !issue_ready;
    assign issue_fire  = issue_valid && issue_ready;
    assign underflow   = wb_valid && (wb_rd != 5'd0) && (cnt_wb == '0);

    always_comb begin
        inc = '0;
        dec = '0;
        for (int i = 1; i < 32; i++) begin
            inc[i] = issue_fire && issue_we && (issue_rd == 5'(i));
            dec[i] = wb_valid && (wb_rd == 5'(i)) && (cnt_q[i] != '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++)
                cnt_q[i] <= '0;
            err <= 1'b0;
        end else begin
            cnt_q[0] <= '0;
            for (int i = 1; i < 32; i++) begin
                if (inc[i] && !dec[i])
                    cnt_q[i] <= cnt_q[i] + CNT_ONE;
                else if (dec[i] && !inc[i])
                    cnt_q[i] <= cnt_q[i] - CNT_ONE;
            end
            if (underflow)
                err <= 1'b1;
        end
    end

    // busy is a pure decode of the counter registers, so it clears
    // asynchronously with reset and never glitches on input changes.
    always_comb begin
        busy = '0;
        for (int i = 1; i < 32; i++)
            busy[i] = (cnt_q[i] != '0);
    end

endmodule

// File: doc/dest_reg_scoreboard.md
# dest_reg_scoreboard

Tracks in-flight writes to the 32 general-purpose registers of the pipelined CPU. The decode stage issues instructions with their 5-bit source and destination register numbers, and write-back retires the 5-bit destination. The block withholds issue while any source, or the destination counter, is not ready. It is the consumer-side counterpart of the destination-register select: it reads back the rt/rd choice made at decode and holds it until write-back.

## Interface
Parameters:
- CNT_W, 2: width of the per-register pending-write counter. A register can have at most 2^CNT_W-1 outstanding writes.
- WB_BYPASS, 1: when 1, a write-back in the same cycle clears a source hazard whose counter is 1. When 0, the hazard clears one cycle later.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- issue_valid  in  1  decode presents an instruction.
- issue_ready  out  1  scoreboard accepts it. Issue fires when issue_valid && issue_ready.
- issue_we  in  1  the instruction writes a register.
- issue_rd  in  5  destination register number (the rt/rd select result).
- issue_rs  in  5  first source register.
- issue_rt  in  5  second source register.
- issue_use_rs  in  1  the rs operand is read.
- issue_use_rt  in  1  the rt operand is read.
- wb_valid  in  1  write-back retires one write this cycle.
- wb_rd  in  5  register number being retired.
- busy  out  32  bit i is 1 when the counter for register i is non-zero. Registered.
- stall  out  1  equal to issue_valid && !issue_ready.
- err  out  1  sticky flag. Set on retire-underflow; cleared only by reset.

## Operation
- State: cnt[1..31], each CNT_W bits wide. Register 0 has no counter; busy[0] is always 0.
- hazard_rs = issue_use_rs && rs≠0 && cnt[rs]≠0, except when WB_BYPASS=1 && wb_valid && wb_rd==rs && cnt[rs]==1. hazard_rt is defined the same way for rt.
- full_rd = issue_we && rd≠0 && cnt[rd]==max.
  - When a write-back to the same rd occurs in the same cycle, full_rd is 0 (the net count is unchanged).
- issue_ready = !hazard_rs && !hazard_rt && !full_rd. issue_ready is combinational from registered state and the current inputs, and does not depend on issue_valid.
- Per-register update each cycle for register r≠0:
  - inc = issue fires && issue_we && rd==r.
  - dec = wb_valid && wb_rd==r && cnt[r]≠0.
  - inc only: cnt+1. dec only: cnt−1. Both, or neither: cnt holds.
- wb_valid with wb_rd==r and cnt[r]==0 (r≠0): no counter change, err is set.
- wb_valid with wb_rd==0: ignored, no error.
- Issue with issue_we && rd==0: accepted, no count change.
- Write-after-write to the same rd is allowed up to max outstanding. Retirement is assumed in order, so the counter alone is sufficient.

## Timing
- Reset (rst_n low, asynchronous): all cnt cleared, busy=0, err=0. While in reset, issue_ready reflects the cleared state and is 1. A reset asserted mid-operation discards all pending writes immediately.
- Latency:
  - An issue at edge N makes busy[rd] 1 after edge N.
  - A dependent instruction is stalled from cycle N+1.
  - A retire at edge M clears busy after edge M when the count reaches 0.
  - With WB_BYPASS=1, the dependent instruction issues in cycle M itself (zero-cycle hazard release). With WB_BYPASS=0, it issues at M+1.
- stall and issue_ready have no register stage. busy and err are registered outputs.
- Simultaneous issue and retire on different registers update both counters independently in the same edge.

## Test plan
- Reset then idle:
  - Required: busy=0, err=0, issue_ready=1.
  - Apply rst_n low mid-run with cnt[5]=2; busy[5] must drop asynchronously, before the next clk edge.
- RAW stall:
  - Issue we=1 rd=8 at cycle 1. At cycle 2 present rs=8, use_rs=1: stall=1.
  - wb_valid wb_rd=8 at cycle 5: issue_ready=1 in cycle 5 (WB_BYPASS=1), or in cycle 6 (WB_BYPASS=0). busy[8] is 0 after edge 5.
- Register 0:
  - Issue rd=0 we=1 repeatedly: busy stays 0.
  - rs=0 with use_rs=1 never stalls.
  - wb_rd=0 leaves err=0.
- Counter saturation (CNT_W=2):
  - Three issues with rd=3 give cnt=3. A fourth issue with rd=3 stalls.
  - The same fourth issue presented together with wb_rd=3 is accepted, and cnt stays 3.
- Underflow: wb_valid wb_rd=12 with cnt[12]=0 sets err=1; err stays 1 until reset, and all counters are unchanged.
- Concurrent traffic:
  - Issue rd=4 and retire rd=9 (cnt[9]=1) in the same cycle: busy[4]=1 and busy[9]=0 after the edge.
  - Use a random issue/retire stream checked against a reference model of the counters.
